// File: rtl/game_input_conditioner_pkg.sv
// ============================================================================
// Module      : game_input_conditioner_pkg
// Description : Shared channel indices, counts and default timing constants
//               for the board input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_input_conditioner_pkg;

  localparam int BTN1_IDX = 0;
  localparam int BTN6_IDX = 1;
  localparam int SW7_IDX  = 7;

  localparam int NUM_BTN = 2;
  localparam int NUM_SW  = 8;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 20000;
  localparam int DEFAULT_LONG_CYCLES     = 2000000;

endpackage

`default_nettype wire

// File: rtl/game_input_conditioner_debounce_cell.sv
// ============================================================================
// Module      : game_input_conditioner_debounce_cell
// Description : Debounce cell: two-flop synchroniser, stability counter,
//               accepted level and registered one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_input_conditioner_debounce_cell
  import game_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any sample agreeing with the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
        rise_d   = s2_q;
        fall_d   = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/game_input_conditioner.sv
// ============================================================================
// Module      : game_input_conditioner
// Description : Synchronises, debounces and edge-detects BTN1/BTN6/SW[7:0].
//               Long-press detection is built when INPUT_COND_LONGPRESS_EN
//               is defined; otherwise btn_long is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_input_conditioner
  import game_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn_raw,
  input  logic [7:0] sw_raw,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic [1:0] btn_long,
  output logic [7:0] sw_level,
  output logic [7:0] sw_change
);

  logic [NUM_BTN-1:0] btn_lvl;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_fall_unused;
  logic [NUM_SW-1:0]  sw_rise;
  logic [NUM_SW-1:0]  sw_fall;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    game_input_conditioner_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_raw[i]),
      .level_o(btn_lvl[i]),
      .rise_o (btn_rise[i]),
      .fall_o (btn_fall_unused[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    game_input_conditioner_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (sw_raw[i]),
      .level_o(sw_level[i]),
      .rise_o (sw_rise[i]),
      .fall_o (sw_fall[i])
    );
  end

  assign btn_level = btn_lvl;
  assign btn_press = btn_rise;
  assign sw_change = sw_rise | sw_fall;

`ifdef INPUT_COND_LONGPRESS_EN
  localparam int            HW       = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_long
    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Saturating hold time; the pulse fires only on the step into HOLD_MAX.
    always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      if (btn_lvl[i]) begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        long_d = (hold_q == HOLD_PRE);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    assign btn_long[i] = long_q;
  end
`else
  logic [$clog2(LONG_CYCLES + 1)-1:0] unused_hold;
  assign unused_hold = '0;
  assign btn_long    = '0;
`endif

endmodule

`default_nettype wire
